lsu_split_ctrl: RTL and testbench

- Sequences LSU data-bus accesses for the EX stage. Splits misaligned word and halfword accesses into two aligned bus transactions.
- During the second phase it drives lsu_addr_incr_req_o. This forces the ALU operand-B mux to OP_B_IMM / IMM_B_INCR_ADDR, so the ALU computes last address + 4.
- Stalls EX while busy. Reports a single combined response and error per instruction.
- At most one outstanding bus transaction.

---
 rtl/lsu_split_ctrl_pkg.sv | 26 ++
 rtl/lsu_split_ctrl_be_gen.sv | 37 +++
 rtl/lsu_split_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_split_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_split_ctrl_pkg.sv
// Shared types for the LSU split controller: FSM state encoding, access
// type encoding and a word-alignment helper.
package lsu_split_ctrl_pkg;

  // Access sequencer states. Phase 2 states only occur for misaligned accesses.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT1    = 3'd1,
    RVALID1 = 3'd2,
    GNT2    = 3'd3,
    RVALID2 = 3'd4
  } lsu_split_state_e;

  // Access size as presented by the decoder; 2'b11 is also treated as byte.
  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  // The data bus only ever sees word-aligned addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_split_ctrl_be_gen.sv
// Byte-enable generator: maps access type, byte offset and split phase to
// the bus byte enables, and flags accesses that need a second transaction.
module lsu_split_ctrl_be_gen
  import lsu_split_ctrl_pkg::*;
(
  input  logic [1:0] type_i,
  input  logic [1:0] off_i,
  input  logic       phase_i,
  output logic [3:0] be_o,
  output logic       misaligned_o
);

  // Phase 1 covers the bytes from the offset up to the word end; phase 2
  // covers the bytes that spilled into the next word.
  always_comb begin
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    if (type_i == LSU_WORD) begin
      misaligned_o = (off_i != 2'd0);
      if (phase_i) begin
        be_o = 4'b1111 >> (3'd4 - {1'b0, off_i});
      end else begin
        be_o = 4'b1111 << off_i;
      end
    end else if (type_i == LSU_HALF) begin
      misaligned_o = (off_i == 2'd3);
      if (off_i == 2'd3) begin
        be_o = phase_i ? 4'b0001 : 4'b1000;
      end else begin
        be_o = 4'b0011 << off_i;
      end
    end else begin
      be_o = 4'b0001 << off_i;
    end
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// LSU split controller: sequences EX-stage data-bus accesses, splitting
// misaligned word/half accesses into two aligned transactions, with an
// optional grant/response watchdog (GntTimeout > 0).
// Optional feature macro: LSU_SPLIT_PERF_EN builds a saturating counter of
// accepted misaligned requests; without it perf_misaligned_cnt_o is 0.
module lsu_split_ctrl
  import lsu_split_ctrl_pkg::*;
#(
  parameter int unsigned GntTimeout = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic        data_we_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic        lsu_addr_incr_req_o,
  output logic [31:0] addr_last_o,
  output logic        split_phase_o,
  output logic        busy_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_err_o,
  output logic [31:0] perf_misaligned_cnt_o
);

  lsu_split_state_e state_q, state_d;
  logic        we_q;
  logic [1:0]  type_q;
  logic        misal_q;
  logic [31:0] addr_last_q;
  logic        gap_q;

  logic        accept;
  logic        wd_expired;
  logic [3:0]  be_new, be_lat;
  logic        misal_new, misal_lat;
  logic        phase_lat;

  // Byte enables for a request being issued straight from IDLE.
  lsu_split_ctrl_be_gen u_be_new (
    .type_i       (lsu_type_i),
    .off_i        (adder_result_ex_i[1:0]),
    .phase_i      (1'b0),
    .be_o         (be_new),
    .misaligned_o (misal_new)
  );

  assign phase_lat = (state_q == GNT2);

  // Byte enables for the latched access while waiting for grant.
  lsu_split_ctrl_be_gen u_be_lat (
    .type_i       (type_q),
    .off_i        (addr_last_q[1:0]),
    .phase_i      (phase_lat),
    .be_o         (be_lat),
    .misaligned_o (misal_lat)
  );

  // Next-state and bus outputs; a watchdog abort drops the request and
  // reports an error, but a response that arrives in time always wins.
  always_comb begin
    state_d             = state_q;
    accept              = 1'b0;
    data_req_o          = 1'b0;
    data_addr_o         = 32'h0;
    data_be_o           = 4'b0000;
    data_we_o           = 1'b0;
    lsu_addr_incr_req_o = 1'b0;
    lsu_resp_valid_o    = 1'b0;
    lsu_err_o           = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The cycle right after a response never accepts a new request.
        if (lsu_req_i && !gap_q) begin
          accept      = 1'b1;
          data_req_o  = 1'b1;
          data_addr_o = word_align(adder_result_ex_i);
          data_be_o   = be_new;
          data_we_o   = lsu_we_i;
          // A grant on the zero-cycle issue already completes the handshake.
          state_d     = data_gnt_i ? RVALID1 : GNT1;
        end
      end
      GNT1: begin
        if (wd_expired) begin
          lsu_resp_valid_o = 1'b1;
          lsu_err_o        = 1'b1;
          state_d          = IDLE;
        end else begin
          data_req_o  = 1'b1;
          data_addr_o = word_align(addr_last_q);
          data_be_o   = be_lat;
          data_we_o   = we_q;
          if (data_gnt_i) begin
            state_d = RVALID1;
          end
        end
      end
      RVALID1: begin
        if (data_rvalid_i) begin
          if (data_err_i || !misal_q) begin
            lsu_resp_valid_o = 1'b1;
            lsu_err_o        = data_err_i;
            state_d          = IDLE;
          end else begin
            state_d = GNT2;
          end
        end else if (wd_expired) begin
          lsu_resp_valid_o = 1'b1;
          lsu_err_o        = 1'b1;
          state_d          = IDLE;
        end
      end
      GNT2: begin
        lsu_addr_incr_req_o = 1'b1;
        if (wd_expired) begin
          lsu_resp_valid_o = 1'b1;
          lsu_err_o        = 1'b1;
          state_d          = IDLE;
        end else begin
          // The ALU is forced to produce addr_last + 4 in this phase.
          data_req_o  = 1'b1;
          data_addr_o = word_align(adder_result_ex_i);
          data_be_o   = be_lat;
          data_we_o   = we_q;
          if (data_gnt_i) begin
            state_d = RVALID2;
          end
        end
      end
      RVALID2: begin
        lsu_addr_incr_req_o = 1'b1;
        if (data_rvalid_i) begin
          lsu_resp_valid_o = 1'b1;
          lsu_err_o        = data_err_i;
          state_d          = IDLE;
        end else if (wd_expired) begin
          lsu_resp_valid_o = 1'b1;
          lsu_err_o        = 1'b1;
          state_d          = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the access attributes captured at acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      misal_q     <= 1'b0;
      addr_last_q <= 32'h0;
      gap_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= lsu_resp_valid_o;
      if (accept) begin
        we_q        <= lsu_we_i;
        type_q      <= lsu_type_i;
        misal_q     <= misal_new;
        addr_last_q <= adder_result_ex_i;
      end
    end
  end

  generate
    if (GntTimeout > 0) begin : g_wd
      localparam int unsigned CntW = $clog2(GntTimeout + 1);
      logic [CntW-1:0] wd_cnt_q;

      assign wd_expired = (wd_cnt_q == CntW'(GntTimeout));

      // Cycles spent in the current wait state; restarts on every transition.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wd_cnt_q <= '0;
        end else if (state_d != state_q) begin
          wd_cnt_q <= '0;
        end else if (state_q != IDLE) begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
      end
    end else begin : g_no_wd
      assign wd_expired = 1'b0;
    end
  endgenerate

`ifdef LSU_SPLIT_PERF_EN
  logic [31:0] perf_cnt_q;

  // Saturating count of accepted misaligned requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q <= 32'h0;
    end else if (accept && misal_new && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_misaligned_cnt_o = perf_cnt_q;
`else
  assign perf_misaligned_cnt_o = 32'h0;
`endif

  // misal_lat duplicates misal_q; kept only to make the latched BE path total.
  logic unused_misal_lat;
  assign unused_misal_lat = misal_lat;

  assign addr_last_o   = addr_last_q;
  assign split_phase_o = (state_q == RVALID2);
  assign busy_o        = (state_q != IDLE) || lsu_req_i;

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Directed bench for lsu_split_ctrl with the watchdog set to 8 cycles.
module tb_lsu_split_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] adder_result_ex_i;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic        data_we_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic        lsu_addr_incr_req_o;
  logic [31:0] addr_last_o;
  logic        split_phase_o;
  logic        busy_o;
  logic        lsu_resp_valid_o;
  logic        lsu_err_o;
  logic [31:0] perf_misaligned_cnt_o;

  lsu_split_ctrl #(.GntTimeout(8)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .lsu_req_i             (lsu_req_i),
    .lsu_we_i              (lsu_we_i),
    .lsu_type_i            (lsu_type_i),
    .adder_result_ex_i     (adder_result_ex_i),
    .data_req_o            (data_req_o),
    .data_addr_o           (data_addr_o),
    .data_be_o             (data_be_o),
    .data_we_o             (data_we_o),
    .data_gnt_i            (data_gnt_i),
    .data_rvalid_i         (data_rvalid_i),
    .data_err_i            (data_err_i),
    .lsu_addr_incr_req_o   (lsu_addr_incr_req_o),
    .addr_last_o           (addr_last_o),
    .split_phase_o         (split_phase_o),
    .busy_o                (busy_o),
    .lsu_resp_valid_o      (lsu_resp_valid_o),
    .lsu_err_o             (lsu_err_o),
    .perf_misaligned_cnt_o (perf_misaligned_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Observations of the last access run by do_access.
  int          hs, resp_cnt, incr_cyc, req_cyc;
  logic [31:0] a0, a1;
  logic [3:0]  be0, be1;
  logic        we0, incr_hs0, incr_hs1, resp_err, sp0, sp1, busy0, busy_after, done;

  // One access: request in the first cycle, grant after gd request cycles,
  // rvalid after rd wait cycles (255 = never), per-phase errors e1/e2.
  task automatic do_access(input string name, input logic we, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] addr2,
                           input int gd, input int rd, input logic e1, input logic e2);
    int wait_cnt = 0;
    int rv_cnt = 0;
    int rv_num = 0;
    int cyc = 0;
    bit pend = 0;
    hs = 0; resp_cnt = 0; incr_cyc = 0; req_cyc = 0;
    a0 = '0; a1 = '0; be0 = '0; be1 = '0; we0 = 0; incr_hs0 = 0; incr_hs1 = 0;
    resp_err = 0; sp0 = 0; sp1 = 0; busy0 = 0; done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk_i); #1;
      lsu_req_i = (cyc == 0); lsu_we_i = we; lsu_type_i = typ;
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
      #1;
      adder_result_ex_i = lsu_addr_incr_req_o ? addr2 : addr;
      #1;
      if (cyc == 0) busy0 = busy_o;
      if (lsu_addr_incr_req_o) incr_cyc++;
      if (pend) begin
        if (rv_cnt == rd) begin
          data_rvalid_i = 1;
          data_err_i = (rv_num == 0) ? e1 : e2;
          if (rv_num == 0) sp0 = split_phase_o; else sp1 = split_phase_o;
          rv_num++;
          pend = 0;
        end else begin
          rv_cnt++;
        end
      end
      if (data_req_o) begin
        if (cyc > 0) req_cyc++;
        if (wait_cnt == gd) begin
          data_gnt_i = 1;
          if (hs == 0) begin
            a0 = data_addr_o; be0 = data_be_o; we0 = data_we_o; incr_hs0 = lsu_addr_incr_req_o;
          end else begin
            a1 = data_addr_o; be1 = data_be_o; incr_hs1 = lsu_addr_incr_req_o;
          end
          hs++;
          pend = 1; rv_cnt = 0; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (lsu_resp_valid_o) begin
        resp_cnt++;
        resp_err = lsu_err_o;
        done = 1;
      end
      cyc++;
    end
    @(posedge clk_i); #1;
    lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; adder_result_ex_i = '0;
    #2;
    busy_after = busy_o;
    chk({name, " completes"}, done, 1);
    $display("access %s: hs=%0d a0=%08h be0=%b a1=%08h be1=%b resp=%0d err=%0b incr_cyc=%0d",
             name, hs, a0, be0, a1, be1, resp_cnt, resp_err, incr_cyc);
  endtask

  initial begin
    rst_i = 1; lsu_req_i = 0; lsu_we_i = 0; lsu_type_i = 0; adder_result_ex_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
    #23;
    chk("rst data_req", data_req_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst resp", lsu_resp_valid_o, 0);
    chk("rst addr_last", addr_last_o, 0);
    chk("rst incr", lsu_addr_incr_req_o, 0);
    chk("rst addr/be", {data_addr_o[27:0], data_be_o}, 0);
    chk("rst perf", perf_misaligned_cnt_o, 0);
    @(posedge clk_i); #1 rst_i = 0;

    // Aligned word load: single request at 0x1000, be 1111.
    do_access("ld_w_1000", 0, 2'b00, 32'h1000, 32'h1004, 1, 1, 0, 0);
    chk("w1000 busy0", busy0, 1);
    chk("w1000 hs", hs, 1);
    chk("w1000 addr", a0, 32'h1000);
    chk("w1000 be", be0, 4'b1111);
    chk("w1000 resp", {resp_cnt[3:0], 3'b0, resp_err}, 32'h10);
    chk("w1000 incr", incr_cyc, 0);
    chk("w1000 split0", sp0, 0);
    chk("w1000 busy after", busy_after, 0);

    // Misaligned word store 0x1002: 0x1000/1100 then 0x1004/0011.
    do_access("st_w_1002", 1, 2'b00, 32'h1002, 32'h1006, 0, 0, 0, 0);
    chk("w1002 hs", hs, 2);
    chk("w1002 a0", a0, 32'h1000);
    chk("w1002 be0", be0, 4'b1100);
    chk("w1002 we", we0, 1);
    chk("w1002 a1", a1, 32'h1004);
    chk("w1002 be1", be1, 4'b0011);
    chk("w1002 incr ph1", incr_hs0, 0);
    chk("w1002 incr ph2", incr_hs1, 1);
    chk("w1002 incr cycles", incr_cyc, 2);
    chk("w1002 split", {sp0, sp1}, 2'b01);
    chk("w1002 addr_last", addr_last_o, 32'h1002);
    chk("w1002 err", resp_err, 0);

    // Half at 0x2003 splits; GNT2 lasts 3 cycles, RVALID2 1 -> 4 incr cycles.
    do_access("ld_h_2003", 0, 2'b01, 32'h2003, 32'h2007, 2, 0, 0, 0);
    chk("h2003 hs", hs, 2);
    chk("h2003 ph1", {a0, 28'h0, be0}, {32'h2000, 28'h0, 4'b1000});
    chk("h2003 ph2", {a1, 28'h0, be1}, {32'h2004, 28'h0, 4'b0001});
    chk("h2003 incr cycles", incr_cyc, 4);

    // Half at 0x2002 is aligned.
    do_access("ld_h_2002", 0, 2'b01, 32'h2002, 32'h2006, 0, 1, 0, 0);
    chk("h2002 hs", hs, 1);
    chk("h2002 be", be0, 4'b1100);
    chk("h2002 addr", a0, 32'h2000);

    // Bytes never split; type 2'b11 behaves as byte.
    do_access("ld_b_3001", 0, 2'b10, 32'h3001, 32'h3005, 0, 0, 0, 0);
    chk("b3001", {hs[3:0], be0}, {4'd1, 4'b0010});
    do_access("ld_b_3003", 0, 2'b11, 32'h3003, 32'h3007, 0, 0, 0, 0);
    chk("b3003", {hs[3:0], be0}, {4'd1, 4'b1000});

    // Phase-1 error on misaligned word: no second request.
    do_access("ld_w_1001_err", 0, 2'b00, 32'h1001, 32'h1005, 0, 0, 1, 0);
    chk("w1001 hs", hs, 1);
    chk("w1001 be0", be0, 4'b1110);
    chk("w1001 err", resp_err, 1);
    chk("w1001 busy after", busy_after, 0);

    // Phase-2 error on misaligned word 0x1003.
    do_access("ld_w_1003_err2", 0, 2'b00, 32'h1003, 32'h1007, 0, 0, 0, 1);
    chk("w1003 be", {be0, be1}, {4'b1000, 4'b0111});
    chk("w1003 err", resp_err, 1);

    // Phase-2 address wraps around the top of the address space.
    do_access("ld_w_wrap", 0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0001, 0, 0, 0, 0);
    chk("wrap a0", a0, 32'hFFFF_FFFC);
    chk("wrap be0", be0, 4'b1110);
    chk("wrap a1", a1, 32'h0000_0000);
    chk("wrap be1", be1, 4'b0001);

    // No grant: request held through 8 GNT1 cycles after the issue cycle.
    do_access("ld_w_nognt", 0, 2'b00, 32'h0040, 32'h0044, 255, 0, 0, 0);
    chk("nognt hs", hs, 0);
    chk("nognt gnt1 req cycles", req_cyc, 8);
    chk("nognt err", resp_err, 1);
    chk("nognt busy after", busy_after, 0);

    // Granted but no response: aborts with error.
    do_access("ld_w_norv", 0, 2'b00, 32'h0080, 32'h0084, 0, 255, 0, 0);
    chk("norv", {hs[3:0], 3'b0, resp_err}, {4'd1, 4'd1});

    // Reset while in RVALID2, then a stray rvalid.
    @(posedge clk_i); #1;
    lsu_req_i = 1; lsu_we_i = 0; lsu_type_i = 2'b00; adder_result_ex_i = 32'h1002; data_gnt_i = 1;
    @(posedge clk_i); #1;
    lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    @(posedge clk_i); #1;
    data_rvalid_i = 0; adder_result_ex_i = 32'h1006; data_gnt_i = 1;
    @(posedge clk_i); #1;
    data_gnt_i = 0;
    #1;
    chk("rvalid2 incr", lsu_addr_incr_req_o, 1);
    chk("rvalid2 busy", busy_o, 1);
    rst_i = 1;
    #1;
    chk("arst data_req", data_req_o, 0);
    chk("arst incr", lsu_addr_incr_req_o, 0);
    chk("arst busy", busy_o, 0);
    chk("arst addr_last", addr_last_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    @(posedge clk_i); #1 data_rvalid_i = 1; data_err_i = 1;
    #1;
    chk("stray rvalid resp", lsu_resp_valid_o, 0);
    @(posedge clk_i); #1 data_rvalid_i = 0; data_err_i = 0;
    #1;
    chk("stray rvalid idle", busy_o, 0);
    $display("reset-in-rvalid2 sequence done");

    // Three misaligned accesses and one aligned after reset.
    do_access("perf_w_1002", 0, 2'b00, 32'h1002, 32'h1006, 0, 0, 0, 0);
    do_access("perf_h_2003", 0, 2'b01, 32'h2003, 32'h2007, 0, 0, 0, 0);
    do_access("perf_al_4000", 0, 2'b00, 32'h4000, 32'h4004, 0, 0, 0, 0);
    do_access("perf_w_1001", 0, 2'b00, 32'h1001, 32'h1005, 0, 0, 1, 0);
`ifdef LSU_SPLIT_PERF_EN
    chk("perf count", perf_misaligned_cnt_o, 3);
`else
    chk("perf tied off", perf_misaligned_cnt_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
